// File: rtl/sc_fifo_pack_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | sc_fifo_pack_pkg : shared types and helpers for sc_fifo_packer    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package sc_fifo_pack_pkg;

  localparam int MAX_LANES = 32;

  typedef enum logic {ST_RUN, ST_FLUSH} pack_state_t;

  // Thermometer mask with the low 'lanes' bits set.
  function automatic logic [MAX_LANES-1:0] lanes_to_mask(input int unsigned lanes);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_fifo_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | sc_fifo_packer : packs RATIO show-ahead FIFO words into one wide  |
// | valid/ready word, with zero-padded partial flush.  Rev 1.0        |
// +------------------------------------------------------------------+
module sc_fifo_packer
  import sc_fifo_pack_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int RATIO    = 4,
  parameter int CNTW     = 2
) (
  input  logic                      clock,
  input  logic                      sclr,
  input  logic [IN_WIDTH-1:0]       fifo_q,
  input  logic                      fifo_empty,
  output logic                      fifo_rdreq,
  input  logic                      flush,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic [CNTW:0]             out_lanes,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      flush_done
);

  localparam logic [CNTW-1:0] LAST_LANE  = CNTW'(RATIO - 1);
  localparam logic [CNTW:0]   FULL_LANES = (CNTW + 1)'(RATIO);

  pack_state_t               state_q, state_d;
  logic [CNTW-1:0]           lane_cnt_q, lane_cnt_d;
  logic [IN_WIDTH-1:0]       acc_q [RATIO];
  logic [IN_WIDTH-1:0]       acc_d [RATIO];
  logic [RATIO-1:0]          acc_we;
  logic                      acc_clr;
  logic [IN_WIDTH*RATIO-1:0] out_data_q, out_data_d;
  logic [CNTW:0]             out_lanes_q, out_lanes_d;
  logic                      out_valid_q, out_valid_d;
  logic                      flush_done_q, flush_done_d;
  logic                      out_free, last_lane, pop, flush_fire;
  logic [RATIO-1:0]          lane_mask;

  assign lane_mask = RATIO'(lanes_to_mask(32'(lane_cnt_q)));

  always_comb begin
    out_free   = ~out_valid_q | out_ready;
    last_lane  = (lane_cnt_q == LAST_LANE);
    // The last lane can only be taken when the output register is free to reload.
    pop        = ~fifo_empty & ~(last_lane & ~out_free) & ~sclr;
    flush_fire = (state_q == ST_FLUSH) & fifo_empty & out_free & ~pop;
  end

  assign fifo_rdreq = pop;

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    out_data_d   = out_data_q;
    out_lanes_d  = out_lanes_q;
    out_valid_d  = out_valid_q & ~out_ready;
    flush_done_d = 1'b0;
    acc_we       = '0;
    acc_clr      = 1'b0;

    if (pop) begin
      if (last_lane) begin
        for (int i = 0; i < RATIO - 1; i++) begin
          out_data_d[i*IN_WIDTH +: IN_WIDTH] = acc_q[i];
        end
        out_data_d[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = fifo_q;
        out_lanes_d = FULL_LANES;
        out_valid_d = 1'b1;
        lane_cnt_d  = '0;
        acc_clr     = 1'b1;
      end else begin
        acc_we[lane_cnt_q] = 1'b1;
        lane_cnt_d         = lane_cnt_q + CNTW'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_fire) begin
          if (lane_cnt_q != '0) begin
            for (int i = 0; i < RATIO; i++) begin
              out_data_d[i*IN_WIDTH +: IN_WIDTH] = lane_mask[i] ? acc_q[i] : '0;
            end
            out_lanes_d = {1'b0, lane_cnt_q};
            out_valid_d = 1'b1;
            lane_cnt_d  = '0;
            acc_clr     = 1'b1;
          end
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
    endcase

    for (int i = 0; i < RATIO; i++) begin
      acc_d[i] = acc_clr ? '0 : (acc_we[i] ? fifo_q : acc_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q      <= ST_RUN;
      lane_cnt_q   <= '0;
      out_data_q   <= '0;
      out_lanes_q  <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < RATIO; i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      out_data_q   <= out_data_d;
      out_lanes_q  <= out_lanes_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
      for (int i = 0; i < RATIO; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign out_data   = out_data_q;
  assign out_lanes  = out_lanes_q;
  assign out_valid  = out_valid_q;
  assign flush_done = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_fifo_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_sc_fifo_packer : randomized bench with a queue-based FIFO and  |
// | packing reference model.  Rev 1.0                                 |
// +------------------------------------------------------------------+
module tb_sc_fifo_packer;

  localparam int IN_WIDTH = 16;
  localparam int RATIO    = 4;
  localparam int CNTW     = 2;
  localparam int OW       = IN_WIDTH * RATIO;

  logic                clock = 1'b0;
  logic                sclr;
  logic [IN_WIDTH-1:0] fifo_q;
  logic                fifo_empty;
  logic                fifo_rdreq;
  logic                flush;
  logic [OW-1:0]       out_data;
  logic [CNTW:0]       out_lanes;
  logic                out_valid;
  logic                out_ready;
  logic                flush_done;

  sc_fifo_packer #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO),
    .CNTW     (CNTW)
  ) dut (
    .clock      (clock),
    .sclr       (sclr),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .flush      (flush),
    .out_data   (out_data),
    .out_lanes  (out_lanes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_done (flush_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OW-1:0] data;
    logic [CNTW:0] lanes;
  } pkt_t;

  logic [IN_WIDTH-1:0] fifo_mem [$];
  logic [IN_WIDTH-1:0] pend [$];
  pkt_t                exp_q [$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  bit            pop_seen      = 1'b0;
  bit            flush_pending = 1'b0;
  bit            rst_prev      = 1'b0;
  bit            hold_prev     = 1'b0;
  bit            full_prev     = 1'b0;
  logic [OW-1:0] hold_data;
  logic [CNTW:0] hold_lanes;

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Lane 0 is the oldest word; unfilled lanes are zero.
  function automatic pkt_t make_pkt();
    pkt_t p;
    p.data = '0;
    for (int i = 0; i < pend.size(); i++) p.data[i*IN_WIDTH +: IN_WIDTH] = pend[i];
    p.lanes = (CNTW + 1)'(pend.size());
    return p;
  endfunction

  always @(negedge clock) begin
    pkt_t p;
    bit   exp_rd;
    if (sclr) begin
      check_eq("rdreq_in_reset", {63'd0, fifo_rdreq}, 64'd0);
      pend.delete();
      exp_q.delete();
      flush_pending = 1'b0;
      rst_prev      = 1'b1;
      hold_prev     = 1'b0;
      full_prev     = 1'b0;
      pop_seen      = 1'b0;
    end else begin
      if (rst_prev) begin
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_lanes", {61'd0, out_lanes}, 64'd0);
        check_eq("rst_flush_done", {63'd0, flush_done}, 64'd0);
        rst_prev = 1'b0;
      end
      if (hold_prev) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_data", out_data, hold_data);
        check_eq("hold_lanes", {61'd0, out_lanes}, {61'd0, hold_lanes});
      end
      if (full_prev) check_eq("latency_valid", {63'd0, out_valid}, 64'd1);
      if (flush_done) begin
        check_eq("flush_done_expected", {63'd0, flush_pending}, 64'd1);
        if (pend.size() > 0) begin
          exp_q.push_back(make_pkt());
          pend.delete();
        end
        flush_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", {63'd0, out_valid}, 64'd0);
        end else begin
          p = exp_q.pop_front();
          check_eq("out_data", out_data, p.data);
          check_eq("out_lanes", {61'd0, out_lanes}, {61'd0, p.lanes});
        end
      end
      exp_rd = !fifo_empty && !(pend.size() == RATIO - 1 && out_valid && !out_ready);
      check_eq("rdreq", {63'd0, fifo_rdreq}, {63'd0, exp_rd});
      full_prev = 1'b0;
      if (fifo_rdreq && !fifo_empty) begin
        pend.push_back(fifo_q);
        if (pend.size() == RATIO) begin
          exp_q.push_back(make_pkt());
          pend.delete();
          full_prev = 1'b1;
        end
      end
      pop_seen   = fifo_rdreq && !fifo_empty;
      hold_prev  = out_valid && !out_ready;
      hold_data  = out_data;
      hold_lanes = out_lanes;
    end
  end

  // Show-ahead FIFO model: the head word leaves on the edge where rdreq was high.
  always @(posedge clock) begin
    #2;
    if (pop_seen && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    pop_seen   = 1'b0;
    fifo_empty = (fifo_mem.size() == 0);
    fifo_q     = fifo_empty ? 16'hDEAD : fifo_mem[0];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_flush();
    flush         = 1'b1;
    flush_pending = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fifo_mem.size() == 0 && exp_q.size() == 0 && !flush_pending && !out_valid) begin
        idle = 1'b1;
        break;
      end
    end
    check_eq("drain_timeout", {63'd0, idle}, 64'd1);
  endtask

  initial begin
    sclr       = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_q     = '0;
    repeat (3) tick();
    sclr = 1'b0;

    for (int w = 1; w <= 4; w++) fifo_mem.push_back(IN_WIDTH'(w));
    wait_idle();

    for (int w = 0; w < 40; w++) fifo_mem.push_back(IN_WIDTH'($urandom));
    wait_idle();

    out_ready = 1'b0;
    for (int w = 1; w <= 8; w++) fifo_mem.push_back(IN_WIDTH'(16'h0010 + w));
    repeat (12) tick();
    out_ready = 1'b1;
    wait_idle();

    fifo_mem.push_back(16'hAAAA);
    fifo_mem.push_back(16'hBBBB);
    repeat (4) tick();
    pulse_flush();
    wait_idle();

    pulse_flush();
    wait_idle();

    out_ready = 1'b0;
    for (int w = 1; w <= 7; w++) fifo_mem.push_back(IN_WIDTH'(16'h0100 + w));
    repeat (10) tick();
    check_eq("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    sclr = 1'b1;
    tick();
    sclr      = 1'b0;
    out_ready = 1'b1;
    for (int w = 1; w <= 4; w++) fifo_mem.push_back(IN_WIDTH'(16'h0200 + w));
    wait_idle();

    for (int c = 0; c < 600; c++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) fifo_mem.push_back(IN_WIDTH'($urandom));
      if (!flush_pending && !flush && $urandom_range(0, 40) == 0) begin
        flush         = 1'b1;
        flush_pending = 1'b1;
      end else begin
        flush = 1'b0;
      end
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    pulse_flush();
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
